mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the bus-side memory responder: widths, FSM encoding, access direction.
package mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: strobe handshake FSM with wait states, tri-state read data,
// and a side-band preload port that only writes while the bus is idle.
module mem_responder #(
  parameter int unsigned ADDR_W   = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = mem_pkg::DATA_W,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] add,
  inout  wire  [DATA_W-1:0] dat,
  input  logic              RD,
  input  logic              WR,
  output logic              rdy,
  output logic              err,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_add,
  input  logic [DATA_W-1:0] pl_dat,
  output logic              pl_rej
);
  import mem_pkg::*;

  localparam bit              ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = ZERO_WAIT ? '0 : CNT_W'(WAIT_CYC - 1);

  logic [1:0]        r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [ADDR_W-1:0] r_a, w_a_d;
  logic              r_dir, w_dir_d;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err, w_err_d;
  logic              r_pl_rej, w_pl_rej_d;

  logic              w_commit;
  logic              w_pl_ok;
  logic              w_act_strobe;
  logic              w_opp_strobe;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_dir;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_act_strobe = (r_dir == DIR_WR) ? WR : RD;
  assign w_opp_strobe = (r_dir == DIR_WR) ? RD : WR;

  // With zero wait states the commit happens on the accepting edge, before a_q is loaded.
  assign w_acc_addr = (r_state == ST_IDLE) ? add : r_a;
  assign w_acc_dir  = (r_state == ST_IDLE) ? WR  : r_dir;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_a_d      = r_a;
    w_dir_d    = r_dir;
    w_err_d    = 1'b0;
    w_pl_rej_d = pl_en;
    w_commit   = 1'b0;
    w_pl_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (RD && WR) begin
          w_err_d = 1'b1;
        end else if (RD || WR) begin
          w_a_d   = add;
          w_dir_d = WR ? DIR_WR : DIR_RD;
          w_cnt_d = CNT_INIT;
          if (ZERO_WAIT) begin
            w_state_d = ST_RESP;
            w_commit  = 1'b1;
          end else begin
            w_state_d = ST_ACCESS;
          end
        end else begin
          w_pl_ok    = pl_en;
          w_pl_rej_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (!w_act_strobe || w_opp_strobe) begin
          w_state_d = ST_IDLE;
          w_err_d   = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_d = ST_RESP;
          w_commit  = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (!w_act_strobe) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Bus commit and preload are mutually exclusive: preload needs both strobes low.
  assign w_we    = !rst && ((w_commit && (w_acc_dir == DIR_WR)) || w_pl_ok);
  assign w_waddr = w_commit ? w_acc_addr : pl_add;
  assign w_wdata = w_commit ? dat : pl_dat;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_acc_addr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_pl_rej <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_err    <= w_err_d;
      r_pl_rej <= w_pl_rej_d;
    end
  end

  always_ff @(posedge clk) begin
    r_a   <= w_a_d;
    r_dir <= w_dir_d;
    if (w_commit && (w_acc_dir == DIR_RD)) r_rdata <= w_mem_rdata;
  end

  assign rdy    = (r_state == ST_RESP);
  assign err    = r_err;
  assign pl_rej = r_pl_rej;

  assign dat = (rdy && (r_dir == DIR_RD) && RD && !WR) ? r_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states) checked against an
// array model of memory contents and the handshake latency rule.
module tb_mem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] bus_add [NI];
  logic       rd      [NI];
  logic       wr      [NI];
  logic       pl_en   [NI];
  logic [7:0] pl_add  [NI];
  logic [7:0] pl_dat  [NI];
  logic       rdy     [NI];
  logic       err     [NI];
  logic       pl_rej  [NI];
  logic       drv_en  [NI];
  logic [7:0] drv_val [NI];
  logic [7:0] dat_rd  [NI];

  int unsigned wait_of [NI] = '{0, 1, 3};

  logic [7:0] mem_m [NI][256];
  bit         known [NI][256];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    wire [7:0] bus;
    assign bus       = drv_en[g] ? drv_val[g] : 8'hzz;
    assign dat_rd[g] = bus;

    mem_responder #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .WAIT_CYC (WC)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .add    (bus_add[g]),
      .dat    (bus),
      .RD     (rd[g]),
      .WR     (wr[g]),
      .rdy    (rdy[g]),
      .err    (err[g]),
      .pl_en  (pl_en[g]),
      .pl_add (pl_add[g]),
      .pl_dat (pl_dat[g]),
      .pl_rej (pl_rej[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench drives 0 weakly-equivalent onto the bus; any DUT drive shows as a nonzero/X value.
  task automatic probe_released(input int k, input string tag);
    drv_val[k] = 8'h00;
    drv_en[k]  = 1'b1;
    #1;
    chk_cnt++;
    if (dat_rd[k] !== 8'h00)
      $display("FAIL %s inst%0d: bus reads %h with bench driving 00, want 00 (DUT released)",
               tag, k, dat_rd[k]);
    else pass_cnt++;
    drv_en[k] = 1'b0;
  endtask

  task automatic wait_rdy(input int k, output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (n == 1) bus_add[k] = 8'($urandom);
      if (rdy[k]) break;
    end
  endtask

  task automatic do_preload(input int k, input logic [7:0] a, input logic [7:0] d);
    pl_en[k] = 1'b1; pl_add[k] = a; pl_dat[k] = d;
    tick();
    pl_en[k] = 1'b0;
    chk_cnt++;
    if (pl_rej[k] !== 1'b0) $display("FAIL preload_rej inst%0d: pl_rej=%b want 0", k, pl_rej[k]);
    else pass_cnt++;
    mem_m[k][a] = d;
    known[k][a] = 1'b1;
  endtask

  task automatic do_read(input int k, input logic [7:0] a);
    int n;
    logic [7:0] exp_d;
    exp_d = mem_m[k][a];
    bus_add[k] = a;
    rd[k] = 1'b1;
    wait_rdy(k, n);
    chk_cnt++;
    if (rdy[k] !== 1'b1 || n != int'(wait_of[k]) + 1)
      $display("FAIL read_latency inst%0d addr %h: rdy=%b after %0d edges, want 1 after %0d",
               k, a, rdy[k], n, wait_of[k] + 1);
    else pass_cnt++;
    repeat ($urandom_range(0, 2)) tick();
    chk_cnt++;
    if (rdy[k] !== 1'b1 || dat_rd[k] !== exp_d)
      $display("FAIL read_data inst%0d addr %h: rdy=%b dat=%h, want rdy=1 dat=%h",
               k, a, rdy[k], dat_rd[k], exp_d);
    else pass_cnt++;
    rd[k] = 1'b0;
    tick();
    chk_cnt++;
    if (rdy[k] !== 1'b0) $display("FAIL read_end inst%0d: rdy=%b want 0", k, rdy[k]);
    else pass_cnt++;
    probe_released(k, "read_release");
  endtask

  task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d);
    int n;
    bus_add[k] = a;
    wr[k] = 1'b1;
    drv_val[k] = d;
    drv_en[k] = 1'b1;
    wait_rdy(k, n);
    chk_cnt++;
    if (rdy[k] !== 1'b1 || n != int'(wait_of[k]) + 1)
      $display("FAIL write_latency inst%0d addr %h: rdy=%b after %0d edges, want 1 after %0d",
               k, a, rdy[k], n, wait_of[k] + 1);
    else pass_cnt++;
    drv_val[k] = 8'($urandom);
    tick();
    wr[k] = 1'b0;
    drv_en[k] = 1'b0;
    tick();
    chk_cnt++;
    if (rdy[k] !== 1'b0) $display("FAIL write_end inst%0d: rdy=%b want 0", k, rdy[k]);
    else pass_cnt++;
    mem_m[k][a] = d;
    known[k][a] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      chk_cnt++;
      if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || pl_rej[k] !== 1'b0)
        $display("FAIL reset inst%0d: rdy=%b err=%b pl_rej=%b, want all 0",
                 k, rdy[k], err[k], pl_rej[k]);
      else pass_cnt++;
      probe_released(k, "reset_release");
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    for (int k = 0; k < NI; k++) do_preload(k, 8'h10, 8'hA5);
    do_read(1, 8'h10);
  endtask

  task automatic test_write_read();
    do_write(1, 8'h20, 8'h3C);
    do_read(1, 8'h20);
  endtask

  task automatic test_wait_states();
    do_read(0, 8'h10);
    do_read(2, 8'h10);
  endtask

  task automatic test_both_strobes();
    bus_add[1] = 8'h20;
    rd[1] = 1'b1; wr[1] = 1'b1;
    tick();
    chk_cnt++;
    if (err[1] !== 1'b1 || rdy[1] !== 1'b0)
      $display("FAIL both_strobes inst1: err=%b rdy=%b, want err=1 rdy=0", err[1], rdy[1]);
    else pass_cnt++;
    probe_released(1, "both_release");
    rd[1] = 1'b0; wr[1] = 1'b0;
    tick();
    chk_cnt++;
    if (err[1] !== 1'b0) $display("FAIL both_err_pulse inst1: err=%b want 0", err[1]);
    else pass_cnt++;
    do_read(1, 8'h20);
  endtask

  task automatic test_abort();
    do_write(2, 8'h20, 8'h3C);
    bus_add[2] = 8'h20; wr[2] = 1'b1; drv_val[2] = 8'hFF; drv_en[2] = 1'b1;
    repeat (2) tick();
    wr[2] = 1'b0; drv_en[2] = 1'b0;
    tick();
    chk_cnt++;
    if (err[2] !== 1'b1 || rdy[2] !== 1'b0)
      $display("FAIL abort_drop inst2: err=%b rdy=%b, want err=1 rdy=0", err[2], rdy[2]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (err[2] !== 1'b0) $display("FAIL abort_err_pulse inst2: err=%b want 0", err[2]);
    else pass_cnt++;
    do_read(2, 8'h20);
    // Opposite strobe rising mid-access also aborts.
    bus_add[2] = 8'h20; rd[2] = 1'b1;
    tick();
    wr[2] = 1'b1; drv_val[2] = 8'h55; drv_en[2] = 1'b1;
    tick();
    chk_cnt++;
    if (err[2] !== 1'b1 || rdy[2] !== 1'b0)
      $display("FAIL abort_opposite inst2: err=%b rdy=%b, want err=1 rdy=0", err[2], rdy[2]);
    else pass_cnt++;
    rd[2] = 1'b0; wr[2] = 1'b0; drv_en[2] = 1'b0;
    tick();
    do_read(2, 8'h20);
  endtask

  task automatic test_reset_mid();
    int n;
    bus_add[1] = 8'h10; rd[1] = 1'b1;
    wait_rdy(1, n);
    chk_cnt++;
    if (rdy[1] !== 1'b1 || dat_rd[1] !== 8'hA5)
      $display("FAIL rst_mid_pre inst1: rdy=%b dat=%h, want rdy=1 dat=a5", rdy[1], dat_rd[1]);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++;
    if (rdy[1] !== 1'b0) $display("FAIL rst_mid_rdy inst1: rdy=%b want 0", rdy[1]);
    else pass_cnt++;
    probe_released(1, "rst_mid_release");
    rst = 1'b0; rd[1] = 1'b0;
    tick();
    do_read(1, 8'h10);
  endtask

  task automatic test_preload_reject();
    int n;
    do_preload(2, 8'h30, 8'h11);
    do_preload(2, 8'h31, 8'h22);
    bus_add[2] = 8'h30; rd[2] = 1'b1;
    tick();
    pl_en[2] = 1'b1; pl_add[2] = 8'h30; pl_dat[2] = 8'h77;
    tick();
    pl_en[2] = 1'b0;
    chk_cnt++;
    if (pl_rej[2] !== 1'b1) $display("FAIL pl_rej_access inst2: pl_rej=%b want 1", pl_rej[2]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (pl_rej[2] !== 1'b0) $display("FAIL pl_rej_pulse inst2: pl_rej=%b want 0", pl_rej[2]);
    else pass_cnt++;
    n = 0;
    while (!rdy[2] && n < 20) begin tick(); n++; end
    chk_cnt++;
    if (rdy[2] !== 1'b1 || dat_rd[2] !== 8'h11)
      $display("FAIL pl_rej_nowrite inst2: rdy=%b dat=%h, want rdy=1 dat=11", rdy[2], dat_rd[2]);
    else pass_cnt++;
    rd[2] = 1'b0;
    tick();
    // Preload in the same cycle as a new strobe loses.
    bus_add[2] = 8'h30; rd[2] = 1'b1;
    pl_en[2] = 1'b1; pl_add[2] = 8'h31; pl_dat[2] = 8'h99;
    tick();
    pl_en[2] = 1'b0;
    chk_cnt++;
    if (pl_rej[2] !== 1'b1) $display("FAIL pl_rej_strobe inst2: pl_rej=%b want 1", pl_rej[2]);
    else pass_cnt++;
    wait_rdy(2, n);
    rd[2] = 1'b0;
    tick();
    do_read(2, 8'h31);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 25; i++) begin
        a = 8'($urandom_range(8'h40, 8'h4F));
        case ($urandom_range(0, 2))
          0:       do_preload(k, a, 8'($urandom));
          1:       do_write(k, a, 8'($urandom));
          default: if (known[k][a]) do_read(k, a); else do_write(k, a, 8'($urandom));
        endcase
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      bus_add[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; pl_en[k] = 1'b0;
      pl_add[k] = '0; pl_dat[k] = '0; drv_en[k] = 1'b0; drv_val[k] = '0;
      for (int a = 0; a < 256; a++) known[k][a] = 1'b0;
    end
    test_reset();
    test_preload_read();
    test_write_read();
    test_wait_states();
    test_both_strobes();
    test_abort();
    test_reset_mid();
    test_preload_reject();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
